// File: rtl/note_sequencer.sv
// Rhythm-game round controller: LFSR note scheduling, hit/miss judging and scoring.
// Optional `COMBO_BONUS_EN adds a streak counter that doubles hit value after four hits.
module note_sequencer #(
  parameter int unsigned WINDOW   = 8,
  parameter int unsigned NOTES    = 32,
  parameter int unsigned MAX_MISS = 8,
  parameter logic [7:0]  SEED     = 8'h01
) (
  input  logic       board_clk,
  input  logic       rst_btn,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] SW,
  output logic [7:0] LED,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StShow, StGap, StOver} state_e;

  localparam logic [8:0] WinLim  = 9'(WINDOW);
  localparam logic [8:0] NoteLim = 9'(NOTES);
  localparam logic [3:0] MissLim = 4'(MAX_MISS);

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] win_q, win_d;
  logic [7:0] note_q, note_d;
  logic [7:0] score_q, score_d;
  logic [3:0] miss_q, miss_d;
  logic [3:0] sw_q;
  logic [7:0] led_q, led_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef COMBO_BONUS_EN
  logic [7:0] streak_q, streak_d;
`endif

  logic [3:0] rise;
  logic [3:0] target;
  logic [3:0] miss_sat;
  logic [8:0] score_sum;
  logic [1:0] hit_add;
  logic       miss_evt;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Lane of the value after v, i.e. bits [1:0] of lfsr_next(v).
  function automatic logic [1:0] preview_lane(input logic [7:0] v);
    return {v[0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  assign rise     = SW & ~sw_q;
  assign target   = onehot(lfsr_q[1:0]);
  assign miss_sat = (miss_q == 4'hF) ? 4'hF : miss_q + 4'd1;

  always_comb begin
    hit_add = 2'd1;
`ifdef COMBO_BONUS_EN
    if (streak_q >= 8'd4) hit_add = 2'd2;
`endif
    score_sum = {1'b0, score_q} + {7'd0, hit_add};
  end

  // State and datapath registers
  always_ff @(posedge board_clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q  <= StIdle;
      lfsr_q   <= SEED;
      win_q    <= '0;
      note_q   <= '0;
      score_q  <= '0;
      miss_q   <= '0;
      sw_q     <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef COMBO_BONUS_EN
      streak_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      win_q    <= win_d;
      note_q   <= note_d;
      score_q  <= score_d;
      miss_q   <= miss_d;
      sw_q     <= SW;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef COMBO_BONUS_EN
      streak_q <= streak_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    win_d    = win_q;
    note_d   = note_q;
    score_d  = score_q;
    miss_d   = miss_q;
    miss_evt = 1'b0;
`ifdef COMBO_BONUS_EN
    streak_d = streak_q;
`endif
    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d  = StShow;
          lfsr_d   = SEED;
          win_d    = '0;
          note_d   = '0;
          score_d  = '0;
          miss_d   = '0;
`ifdef COMBO_BONUS_EN
          streak_d = '0;
`endif
        end
      end
      StShow: begin
        // A press in the same cycle as the expiring tick takes priority.
        if (rise != 4'b0000) begin
          if (rise == target) begin
            score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
            state_d = StGap;
`ifdef COMBO_BONUS_EN
            if (streak_q != 8'hFF) streak_d = streak_q + 8'd1;
`endif
          end else begin
            miss_evt = 1'b1;
          end
        end else if (tick) begin
          win_d = win_q + 8'd1;
          if ({1'b0, win_q} + 9'd1 == WinLim) miss_evt = 1'b1;
        end
        if (miss_evt) begin
          miss_d  = miss_sat;
          state_d = (miss_sat >= MissLim) ? StOver : StGap;
`ifdef COMBO_BONUS_EN
          streak_d = '0;
`endif
        end
      end
      StGap: begin
        if (tick) begin
          lfsr_d = lfsr_next(lfsr_q);
          note_d = note_q + 8'd1;
          win_d  = '0;
          if (({1'b0, note_q} + 9'd1 == NoteLim) || (miss_q >= MissLim)) begin
            state_d = StOver;
          end else begin
            state_d = StShow;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next state so that they come straight from flops.
  always_comb begin
    led_d  = 8'h00;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      StIdle: led_d = 8'h00;
      StShow: begin
        led_d  = {onehot(preview_lane(lfsr_d)), onehot(lfsr_d[1:0])};
        busy_d = 1'b1;
      end
      StGap: begin
        led_d  = {onehot(preview_lane(lfsr_d)), 4'b0000};
        busy_d = 1'b1;
      end
      StOver: begin
        led_d  = 8'hFF;
        done_d = 1'b1;
      end
      default: led_d = 8'h00;
    endcase
  end

  assign LED    = led_q;
  assign score  = score_q;
  assign misses = miss_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Rhythm-game round controller for the Finger-Dancer board top level. It schedules a pseudo-random sequence of notes onto the four switch lanes and drives the target and preview lanes onto `LED`. It judges each switch press as a hit or a miss and keeps score. Score and miss counts feed the existing 7-segment driver (`AN`/`SEG`); the beat strobe comes from the board clock divider.

## Interface
Parameters:
- `WINDOW`, 8: ticks a note stays live before it counts as a miss (1..255).
- `NOTES`, 32: notes per round (1..255).
- `MAX_MISS`, 8: miss count that ends the round early (1..15).
- `SEED`, 8'h01: LFSR seed; must be nonzero.

Ports:
- `board_clk` in 1: the single system clock.
- `rst_btn` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle beat strobe from the divider.
- `start` in 1: one-cycle start/restart pulse.
- `SW` in 4: lane switches, already synchronized to `board_clk`.
- `LED` out 8: `[3:0]` one-hot target lane, `[7:4]` one-hot preview lane.
- `score` out 8: hit score; saturates at 255.
- `misses` out 4: miss count; saturates at 15.
- `busy` out 1: high while a round is running.
- `done` out 1: high in OVER.

## Operation
- LFSR is 8-bit Fibonacci, shifting left. New bit 0 = b7^b5^b4^b3.
- The current lane is `lfsr[1:0]`. The preview lane is bits [1:0] of the next LFSR value.
- Edge detect: `sw_q <= SW` every cycle; `rise = SW & ~sw_q`.
- States: IDLE, SHOW, GAP, OVER.
- IDLE:
  - `LED`=0, `busy`=0. `score` and `misses` hold their last values.
  - `start` → SHOW. Entering SHOW clears `score`, `misses`, the note counter and the window counter, and loads lfsr=`SEED`.
- SHOW:
  - `LED[3:0]`=onehot(current lane), `LED[7:4]`=onehot(preview lane).
  - Hit = `rise` equals exactly onehot(target). Score +1, then go to GAP.
  - Any other nonzero `rise` is a miss; this includes a correct bit together with a wrong bit in the same cycle. Misses +1, then go to GAP.
  - Each `tick` increments the window counter. When the counter reaches `WINDOW` with no `rise`: miss, then go to GAP.
  - If `rise` and the expiring tick arrive in the same cycle, the press wins and the tick is ignored.
- GAP:
  - `LED[3:0]`=0; `LED[7:4]` keeps the preview.
  - Waits for the next `tick`. Then the LFSR advances, the note counter increments and the window counter clears.
  - If the note counter reaches `NOTES`, or misses ≥ `MAX_MISS`, go to OVER; otherwise go to SHOW.
  - A miss that makes misses reach `MAX_MISS` goes to OVER directly, without waiting for a tick.
- OVER:
  - `done`=1, `busy`=0, `LED`=8'hFF. `score` and `misses` are frozen.
  - `start` → SHOW with fresh state.
- `start` while `busy` is high is ignored.
- Switch edges in IDLE, GAP and OVER are ignored, but `sw_q` still tracks `SW`.

## Timing
- Reset (`rst_btn`=0, asynchronous): state IDLE, `LED`=0, `score`=0, `misses`=0, `busy`=0, `done`=0, lfsr=`SEED`, `sw_q`=0.
- Reset asserted mid-round aborts the round immediately.
- `start` sampled on cycle N → SHOW, `busy`=1 and valid `LED` on cycle N+1.
- Press latency: `SW` rising edge present at clock edge N → `score`/`misses` updated and state GAP on edge N+1.
- All outputs are registered; there are no combinational paths from input to output.
- A `tick` is a one-cycle strobe; a held `tick` counts once per cycle.

## Configuration
- `COMBO_BONUS_EN` defined:
  - An 8-bit streak counter counts consecutive hits and clears on any miss or on round start.
  - A hit adds 2 while streak ≥ 4 (streak value before the hit), otherwise 1. Score still saturates at 255.
- `COMBO_BONUS_EN` undefined: every hit adds 1 and no streak logic is built.

## Test plan
- Reset, then `start` with `SEED`=8'h01 → next cycle `LED`=8'b0100_0010, `busy`=1, `score`=0.
- In SHOW with target 4'b0010, raise `SW`=4'b0010 → one cycle later `score`=1, state GAP, `LED[3:0]`=0.
- Raise `SW`=4'b0011 against target 4'b0010 → `misses`=1, `score` unchanged.
- With `WINDOW`=3, send 3 ticks with no press → `misses`=1; a correct press arriving with the 3rd tick counts as a hit instead.
- With `MAX_MISS`=2, cause two misses → `done`=1, `LED`=8'hFF, `busy`=0. Then `start` → `score`=0, `misses`=0, `LED`=8'b0100_0010.
- With `NOTES`=5, hit all 5 → `done`=1 with `score`=5. With `COMBO_BONUS_EN` defined, the same run gives `score`=6.
- Assert `rst_btn` mid-round → all outputs 0 immediately.
